mux_rr_reg: RTL and testbench
=============================

Name: mux_rr_reg

Overview:
- Parametrised, registered N-way datapath selector with valid/ready flow control on every input and on the output.
- Successor to the fixed-width 2/3/4-input combinational selectors in the CPU datapath.
- Two selection modes: direct selection by the `clt` index, or round-robin arbitration among valid inputs.
- Feeds shared consumers (register-file write port, memory request port) from several producers; one transfer per cycle, 1-cycle latency.

Parameters:
- WIDTH, 16, data width of each input and of the output.
- N, 4, number of input channels (2..16).
- SELW, 2, width of `clt`/`out_src`; must equal ceil(log2(N)), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = direct select by `clt`; 1 = round-robin.
- clt  input  SELW  channel index used in direct mode; ignored in round-robin mode.
- sig  input  N*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- sig_valid  input  N  per-channel valid.
- sig_ready  output  N  per-channel ready; combinational; at most one bit high.
- out  output  WIDTH  registered selected data.
- out_src  output  SELW  registered index of the channel that supplied `out`.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out = 0, out_src = 0, out_valid = 0.
  - Round-robin pointer `last` = N-1, so the first search starts at channel 0.
  - sig_ready = 0 while reset is asserted.
- Output slot:
  - Single register stage.
  - `load = !out_valid || out_ready`.
  - When `load` is 0, out, out_src and out_valid hold; all sig_ready are 0.
- Candidate selection (combinational, evaluated every cycle):
  - Direct mode: `eff = (clt < N) ? clt : 0`, so an out-of-range index defaults to channel 0. The candidate is `eff` if `sig_valid[eff]`; otherwise there is no candidate, even if other channels are valid.
  - Round-robin mode: the candidate is the first i with `sig_valid[i]` in the order last+1, last+2, ... wrapping modulo N and ending at `last`. No valid channel means no candidate.
- Transfer:
  - Condition: `load` && a candidate g exists.
  - sig_ready[g] = 1, all other sig_ready = 0.
  - On the next edge: out <= sig[g], out_src <= g, out_valid <= 1.
- Drain:
  - Condition: `load` && no candidate.
  - On the next edge: out_valid <= 0; out and out_src hold their previous values.
- Pointer update:
  - `last` <= g on every transfer, in either mode.
  - This keeps fairness consistent when the mode changes.
  - `last` is unchanged otherwise.
- Throughput: one transfer per cycle when out_ready is held high. Latency from input handshake to out_valid is 1 cycle.
- Mode or clt changes take effect on the same cycle's selection. The registered output is never altered while it is stalled.
- Simultaneous drain and fill (out_valid=1, out_ready=1, candidate present): the new word replaces the old word with no bubble.
- Reset asserted mid-transfer: the output is cleared immediately; no partial state survives. After release, the first round-robin grant goes to the lowest valid channel.
- Wrap-around: with last = N-1 the search begins at channel 0; with last = 0 it begins at channel 1.
- Non-power-of-two N (e.g. N=3, SELW=2):
  - Direct index 3 selects channel 0.
  - The pointer never holds a value of N or above.
- Arithmetic: index wrap is modulo N, not modulo 2^SELW. No width extension is applied to data.

Test Plan:
- Reset, then direct mode, clt=2, sig_valid=4'b0100, sig ch2=16'hBEEF, out_ready=1 -> sig_ready=4'b0100 in cycle 0; out=16'hBEEF, out_src=2, out_valid=1 in cycle 1.
- Direct mode, clt=1, sig_valid=4'b1101 (ch1 not valid) -> sig_ready=0, and out_valid falls to 0 after one cycle. Then clt=3 with N=3 and ch0=16'h0007 valid -> out=16'h0007, out_src=0.
- Round-robin mode, all four channels valid, ch i data = 16'h1000+i, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3; out = 16'h1000, 16'h1001, ... each cycle with no bubbles.
- Stall: out_valid=1 with out=16'h1002, out_ready=0 for 3 cycles while the valid inputs change -> out, out_src and out_valid stay constant and sig_ready=0. After out_ready=1, the next grant is the channel after 2 in round-robin order.
- Round-robin with sig_valid=4'b1001 after last=0 -> grant ch3 then ch0. Switch to direct mode, clt=0 -> grant ch0; switch back to round-robin -> the next grant is ch3.
- Assert rst_n low while out_valid=1 and out_ready=0 -> out=0, out_src=0, out_valid=0 immediately (before the next edge). After release with all channels valid in round-robin mode, the first grant is ch0.

Source files
------------

// File: rtl/mux_rr_reg.sv
// Registered N-way selector with valid/ready flow control.
// A channel is chosen directly by clt, or round-robin among the valid inputs.
module mux_rr_reg #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      clt,
    input  logic [N*WIDTH-1:0]   sig,
    input  logic [N-1:0]         sig_valid,
    output logic [N-1:0]         sig_ready,
    output logic [WIDTH-1:0]     out,
    output logic [SELW-1:0]      out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // One extra bit so last+k (at most 2N-1) never overflows before the modulo-N fold.
    localparam logic [SELW:0]   N_EXT    = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST_RST = SELW'(N - 1);

    logic [WIDTH-1:0] ch [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch[i] = sig[i*WIDTH +: WIDTH];
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic [SELW-1:0]  out_src_q, out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  last_q, last_d;

    logic             load_c;
    logic             cand_found;
    logic [SELW-1:0]  cand;
    logic [SELW-1:0]  eff;
    logic [SELW:0]    probe;

    // Candidate search: direct index (out-of-range falls back to 0) or rotating priority.
    always_comb begin
        load_c     = !out_valid_q || out_ready;
        cand_found = 1'b0;
        cand       = '0;
        eff        = '0;
        probe      = '0;
        if (!mode) begin
            eff = ({1'b0, clt} < N_EXT) ? clt : '0;
            if (sig_valid[eff]) begin
                cand_found = 1'b1;
                cand       = eff;
            end
        end else begin
            for (int unsigned k = 1; k <= N; k++) begin
                probe = {1'b0, last_q} + (SELW+1)'(k);
                if (probe >= N_EXT) begin
                    probe = probe - N_EXT;
                end
                if (!cand_found && sig_valid[probe[SELW-1:0]]) begin
                    cand_found = 1'b1;
                    cand       = probe[SELW-1:0];
                end
            end
        end
    end

    // Grant and next-state for the output slot and round-robin pointer.
    always_comb begin
        sig_ready   = '0;
        out_d       = out_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (rst_n && load_c && cand_found) begin
            sig_ready[cand] = 1'b1;
        end
        if (load_c) begin
            if (cand_found) begin
                out_d       = ch[cand];
                out_src_d   = cand;
                out_valid_d = 1'b1;
                last_d      = cand;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            last_q      <= LAST_RST;
        end else begin
            out_q       <= out_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out       = out_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Scoreboard bench for mux_rr_reg: a 4-channel instance plus a 3-channel instance
// for the non-power-of-two index wrap.
module tb_mux_rr_reg;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  src;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mode;
    logic [1:0]  clt;
    logic [63:0] sig;
    logic [3:0]  sig_valid;
    logic [3:0]  sig_ready;
    logic [15:0] out;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready;

    logic        m3;
    logic [1:0]  c3;
    logic [47:0] s3;
    logic [2:0]  v3;
    logic [2:0]  r3;
    logic [15:0] o3;
    logic [1:0]  os3;
    logic        ov3;
    logic        ordy3;

    mux_rr_reg #(.WIDTH(16), .N(4), .SELW(2)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .clt(clt), .sig(sig),
        .sig_valid(sig_valid), .sig_ready(sig_ready), .out(out),
        .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_rr_reg #(.WIDTH(16), .N(3), .SELW(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(m3), .clt(c3), .sig(s3),
        .sig_valid(v3), .sig_ready(r3), .out(o3),
        .out_src(os3), .out_valid(ov3), .out_ready(ordy3)
    );

    exp_t        exp_q[$];
    logic [15:0] din [4];

    logic        chk_ready, chk_hold, chk3_ready, chk3_hold, done;
    logic [3:0]  exp_ready;
    logic        h_val;
    logic [15:0] h_out;
    logic [1:0]  h_src;
    logic [2:0]  exp_ready3;
    logic        h3_val;
    logic [15:0] h3_out;
    logic [1:0]  h3_src;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor: compares combinational ready, held outputs and every consumed word.
    always @(negedge clk) begin
        if (chk_ready) begin
            n_checks++;
            if (sig_ready !== exp_ready) begin
                n_errors++;
                $display("FAIL sig_ready t=%0t got %b expected %b", $time, sig_ready, exp_ready);
            end
        end
        if (chk_hold) begin
            n_checks++;
            if (out_valid !== h_val || out !== h_out || out_src !== h_src) begin
                n_errors++;
                $display("FAIL out_state t=%0t got v=%b d=%h s=%0d expected v=%b d=%h s=%0d",
                         $time, out_valid, out, out_src, h_val, h_out, h_src);
            end
        end
        if (chk3_ready) begin
            n_checks++;
            if (r3 !== exp_ready3) begin
                n_errors++;
                $display("FAIL n3_sig_ready t=%0t got %b expected %b", $time, r3, exp_ready3);
            end
        end
        if (chk3_hold) begin
            n_checks++;
            if (ov3 !== h3_val || o3 !== h3_out || os3 !== h3_src) begin
                n_errors++;
                $display("FAIL n3_out_state t=%0t got v=%b d=%h s=%0d expected v=%b d=%h s=%0d",
                         $time, ov3, o3, os3, h3_val, h3_out, h3_src);
            end
        end
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_word t=%0t got d=%h s=%0d expected none", $time, out, out_src);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out !== e.data || out_src !== e.src) begin
                    n_errors++;
                    $display("FAIL word t=%0t got d=%h s=%0d expected d=%h s=%0d",
                             $time, out, out_src, e.data, e.src);
                end
            end
        end
        if (done) begin
            n_checks++;
            if (exp_q.size() != 0) begin
                n_errors++;
                $display("FAIL missing_words got %0d left expected 0", exp_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $finish;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic hold(input logic v, input logic [15:0] d, input logic [1:0] s);
        chk_hold = 1'b1;
        h_val    = v;
        h_out    = d;
        h_src    = s;
    endtask

    // Drive the 4-channel DUT for one cycle; push the granted word if it will be consumed.
    task automatic drive(input logic md, input logic [1:0] c, input logic [3:0] v,
                         input logic ordy, input logic [3:0] er, input logic psh);
        mode      = md;
        clt       = c;
        sig_valid = v;
        out_ready = ordy;
        sig       = {din[3], din[2], din[1], din[0]};
        exp_ready = er;
        chk_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (psh && er[i]) begin
                exp_t e;
                e.data = din[i];
                e.src  = 2'(i);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Drive the 3-channel DUT for one cycle while the 4-channel DUT idles.
    task automatic step3(input logic md, input logic [1:0] c, input logic [2:0] v,
                         input logic [2:0] er, input logic hv, input logic [15:0] hd,
                         input logic [1:0] hs);
        m3         = md;
        c3         = c;
        v3         = v;
        exp_ready3 = er;
        chk3_ready = 1'b1;
        chk3_hold  = 1'b1;
        h3_val     = hv;
        h3_out     = hd;
        h3_src     = hs;
        drive(1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0);
    endtask

    initial begin
        logic [3:0] rr;
        done      = 1'b0;
        chk3_hold = 1'b0;
        h3_val    = 1'b0;
        h3_out    = '0;
        h3_src    = '0;
        for (int i = 0; i < 4; i++) din[i] = 16'h0000;

        // Reset with live inputs: outputs cleared, no ready raised.
        rst_n      = 1'b0;
        mode       = 1'b1;
        clt        = 2'd0;
        sig        = '0;
        sig_valid  = 4'b1111;
        out_ready  = 1'b1;
        exp_ready  = 4'b0000;
        chk_ready  = 1'b1;
        hold(1'b0, 16'h0000, 2'd0);
        m3         = 1'b1;
        c3         = 2'd0;
        s3         = {16'h0022, 16'h0011, 16'h0007};
        v3         = 3'b111;
        ordy3      = 1'b1;
        exp_ready3 = 3'b000;
        chk3_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n    = 1'b1;
        chk_hold = 1'b0;

        // N=3: out-of-range index maps to ch0; round-robin wraps modulo 3.
        step3(1'b0, 2'd3, 3'b001, 3'b001, 1'b0, 16'h0000, 2'd0);
        step3(1'b0, 2'd3, 3'b010, 3'b000, 1'b1, 16'h0007, 2'd0);
        step3(1'b1, 2'd0, 3'b111, 3'b010, 1'b0, 16'h0007, 2'd0);
        step3(1'b1, 2'd0, 3'b111, 3'b100, 1'b1, 16'h0011, 2'd1);
        step3(1'b1, 2'd0, 3'b111, 3'b001, 1'b1, 16'h0022, 2'd2);
        step3(1'b1, 2'd0, 3'b000, 3'b000, 1'b1, 16'h0007, 2'd0);
        chk3_ready = 1'b0;
        chk3_hold  = 1'b0;

        // Direct select, then an invalid direct target drains the slot.
        din[2] = 16'hBEEF;
        drive(1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1);
        hold(1'b1, 16'hBEEF, 2'd2);
        drive(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0);
        hold(1'b0, 16'hBEEF, 2'd2);
        drive(1'b0, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0);
        chk_hold = 1'b0;

        // Back-to-back round-robin, pointer parked on ch3 first.
        for (int i = 0; i < 4; i++) din[i] = 16'h1000 + 16'(i);
        drive(1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1);
        for (int k = 0; k < 11; k++) begin
            rr = 4'b0001 << (k % 4);
            drive(1'b1, 2'd0, 4'b1111, 1'b1, rr, 1'b1);
        end

        // Stall on word 1002 while inputs change.
        hold(1'b1, 16'h1002, 2'd2);
        drive(1'b1, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b0);
        drive(1'b1, 2'd0, 4'b0110, 1'b0, 4'b0000, 1'b0);
        drive(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b0);
        chk_hold = 1'b0;
        drive(1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1);

        // Pointer shared across modes.
        drive(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1);
        drive(1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1);
        drive(1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1);
        drive(1'b0, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1);
        drive(1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1);
        drive(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0);

        // Load a word that reset will discard, stall it, then reset mid-cycle.
        drive(1'b1, 2'd0, 4'b0100, 1'b0, 4'b0100, 1'b0);
        hold(1'b1, 16'h1002, 2'd2);
        drive(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b0);
        rst_n = 1'b0;
        hold(1'b0, 16'h0000, 2'd0);
        drive(1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b0);
        chk_hold = 1'b0;
        rst_n    = 1'b1;
        drive(1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1);
        drive(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0);
        drive(1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0);

        chk_ready = 1'b0;
        done      = 1'b1;
    end

endmodule
